ddram_read_arbiter: RTL
=======================

DDRAM_READ_ARBITER -- requirements
Module: ddram_read_arbiter

Interface
REQ-001 SHALL have parameter WDOG_CYCLES, default 4096, meaning the maximum number of cycles in DATA before the burst is aborted.
REQ-002 SHALL have these ports, in this order:
- clock  in  1  system clock, all logic on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- req_addr_0/1/2  in  29  word address per requester.
- req_burst_0/1/2  in  8  burst length in 64-bit words per requester.
- req_rd_0/1/2  in  1  level read request per requester; held high until its ack.
- req_ack_0/1/2  out  1  one-cycle pulse when that request is accepted by DDR.
- req_valid_0/1/2  out  1  one-cycle pulse per returned word for that requester.
- rd_data  out  64  returned word, shared by all requesters.
- ddram_addr  out  29  DDR controller address.
- ddram_burstcnt  out  8  DDR controller burst count.
- ddram_rd  out  1  DDR controller read strobe.
- ddram_busy  in  1  DDR controller waitrequest.
- ddram_valid  in  1  DDR controller read data valid.
- ddram_readdata  in  64  DDR controller read data.
- wdog_err  out  1  one-cycle pulse on burst abort.

Function
REQ-003 SHALL implement states IDLE, ISSUE and DATA; the state SHALL be IDLE after reset.
REQ-004 IDLE: if any req_rd_k is high, SHALL grant round-robin starting at index rr_ptr, ascending with wrap 2->0.
REQ-005 On a grant, SHALL latch the granted requester's address and burst into ddram_addr and ddram_burstcnt, drive ddram_rd=1 and go to ISSUE.
- ddram_rd SHALL be high in the cycle after the request was sampled.
REQ-006 IDLE grant with burst=0: SHALL NOT drive a DDR read, SHALL pulse req_ack_k next cycle and SHALL advance rr_ptr; the state SHALL stay IDLE.
REQ-007 ISSUE: SHALL keep ddram_rd, ddram_addr and ddram_burstcnt stable while ddram_busy=1.
REQ-008 ISSUE, ddram_rd=1 and ddram_busy=0 (acceptance cycle): in the next cycle SHALL:
- drop ddram_rd;
- pulse req_ack_k for the granted requester;
- clear beat_cnt;
- go to DATA.
REQ-009 DATA: on each ddram_valid=1, SHALL register ddram_readdata into rd_data and pulse req_valid_k for the granted requester only, one cycle after ddram_valid.
- beat_cnt (8 bits) SHALL increment on each valid beat.
REQ-010 DATA: when the beat that makes beat_cnt equal to the latched burst arrives, SHALL return to IDLE next cycle and set rr_ptr to granted index +1 mod 3.
REQ-011 A new grant SHALL be possible in the IDLE cycle immediately after DATA ends, giving a 2-cycle gap minimum between bursts.
REQ-012 ddram_valid outside DATA SHALL be ignored: no req_valid pulse and no state change.
REQ-013 Only one req_ack and at most one req_valid SHALL be high in any cycle; neither SHALL ever go to a non-granted requester.
REQ-014 A requester dropping req_rd after grant but before ack SHALL NOT cancel the burst; the arbiter SHALL complete it and still pulse ack.
REQ-015 Watchdog: a counter SHALL run only in DATA and clear on entering DATA.
- On reaching WDOG_CYCLES, SHALL pulse wdog_err, return to IDLE, advance rr_ptr and discard further beats.
REQ-016 rd_data SHALL hold its last value when no valid beat occurs.
REQ-017 Requests arriving while not IDLE SHALL wait; no requester SHALL wait more than two other bursts once its req_rd is high.

Reset
REQ-018 While reset_n=0, SHALL set state=IDLE, rr_ptr=0, ddram_rd=0, ddram_burstcnt=0, ddram_addr=0, beat_cnt=0, all req_ack=0, all req_valid=0, wdog_err=0, rd_data=0.
REQ-019 Reset asserted mid-burst SHALL abort immediately with no further ack or valid pulses; beats arriving after release SHALL be ignored per REQ-012.

Verification
REQ-020 Single request: req_rd_1 with addr 0x0001000 and burst 8, busy=0 -> ddram_rd one cycle later with addr 0x0001000 and burstcnt 8, then req_ack_1, then 8 req_valid_1 pulses with data matching, then IDLE.
REQ-021 All three requesting with rr_ptr=0 -> grant order 0,1,2,0; each gets only its own valid pulses.
REQ-022 busy held high 5 cycles at issue -> ddram_rd, addr and burstcnt stable for 6 cycles; ack exactly once after acceptance.
REQ-023 burst=0 on requester 2 -> ack_2 pulse, no ddram_rd, rr_ptr advances to 0.
REQ-024 WDOG_CYCLES=16 with burst 8 and only 3 beats returned -> wdog_err pulse 16 cycles into DATA, IDLE next, a late 4th beat produces no req_valid.
REQ-025 reset_n low after the 4th of 8 beats, then released -> all outputs at reset values, remaining beats ignored, a new request is served normally.

Source files
------------

// File: rtl/ddram_read_arbiter.sv
// ddram_read_arbiter
//   Round-robin read arbiter that lets three requesters share one DDR
//   controller read port. A granted request is issued as a single burst.
//   Returned beats are forwarded on a shared data bus, with a per-requester
//   valid pulse. A watchdog aborts a burst whose data never completes.
//
// Ports
//   clock, reset_n             system clock (rising edge), async active-low reset
//   req_addr_k / req_burst_k   word address and burst length of requester k
//   req_rd_k                   level request of requester k, held until its ack
//   req_ack_k                  one-cycle pulse when requester k's burst is accepted
//   req_valid_k                one-cycle pulse per returned word for requester k
//   rd_data                    returned word, shared by all requesters
//   ddram_addr/burstcnt/rd     DDR controller read command
//   ddram_busy                 DDR controller waitrequest
//   ddram_valid/readdata       DDR controller read data return
//   wdog_err                   one-cycle pulse when a burst is aborted
module ddram_read_arbiter #(
  parameter int WDOG_CYCLES = 4096
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [28:0] req_addr_0,
  input  logic [28:0] req_addr_1,
  input  logic [28:0] req_addr_2,
  input  logic [7:0]  req_burst_0,
  input  logic [7:0]  req_burst_1,
  input  logic [7:0]  req_burst_2,
  input  logic        req_rd_0,
  input  logic        req_rd_1,
  input  logic        req_rd_2,
  output logic        req_ack_0,
  output logic        req_ack_1,
  output logic        req_ack_2,
  output logic        req_valid_0,
  output logic        req_valid_1,
  output logic        req_valid_2,
  output logic [63:0] rd_data,
  output logic [28:0] ddram_addr,
  output logic [7:0]  ddram_burstcnt,
  output logic        ddram_rd,
  input  logic        ddram_busy,
  input  logic        ddram_valid,
  input  logic [63:0] ddram_readdata,
  output logic        wdog_err
);

  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    rr_ptr;
  logic [1:0]    gnt;
  logic [7:0]    beat_cnt;
  logic [WW-1:0] wdog_cnt;
  logic [2:0]    ack;
  logic [2:0]    valid;

  logic [3:0]    pending;
  logic [1:0]    idx1;
  logic [1:0]    idx2;
  logic [1:0]    pick;
  logic          pick_ok;
  logic [28:0]   pick_addr;
  logic [7:0]    pick_burst;
  logic [7:0]    beat_next;

  // Next requester index in round-robin order, wrapping 2 -> 0.
  function automatic logic [1:0] next_idx(input logic [1:0] p);
    next_idx = (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A requester whose ack is on the wire this cycle still holds req_rd;
  // masking it stops a zero-length request from being granted twice.
  assign pending   = {1'b0, req_rd_2 & ~ack[2], req_rd_1 & ~ack[1], req_rd_0 & ~ack[0]};
  assign beat_next = beat_cnt + 8'd1;

  assign req_ack_0   = ack[0];
  assign req_ack_1   = ack[1];
  assign req_ack_2   = ack[2];
  assign req_valid_0 = valid[0];
  assign req_valid_1 = valid[1];
  assign req_valid_2 = valid[2];

  // Round-robin pick: first pending requester at or after rr_ptr.
  always_comb begin
    idx1    = next_idx(rr_ptr);
    idx2    = next_idx(idx1);
    pick    = rr_ptr;
    pick_ok = 1'b1;
    if (pending[rr_ptr]) begin
      pick = rr_ptr;
    end else if (pending[idx1]) begin
      pick = idx1;
    end else if (pending[idx2]) begin
      pick = idx2;
    end else begin
      pick_ok = 1'b0;
    end
  end

  // Address / burst of the picked requester.
  always_comb begin
    pick_addr  = 29'd0;
    pick_burst = 8'd0;
    case (pick)
      2'd0: begin
        pick_addr  = req_addr_0;
        pick_burst = req_burst_0;
      end
      2'd1: begin
        pick_addr  = req_addr_1;
        pick_burst = req_burst_1;
      end
      2'd2: begin
        pick_addr  = req_addr_2;
        pick_burst = req_burst_2;
      end
      default: begin
        pick_addr  = 29'd0;
        pick_burst = 8'd0;
      end
    endcase
  end

  // Arbiter FSM with registered command, ack, valid and watchdog outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      rr_ptr         <= 2'd0;
      gnt            <= 2'd0;
      beat_cnt       <= 8'd0;
      wdog_cnt       <= '0;
      ack            <= 3'b000;
      valid          <= 3'b000;
      wdog_err       <= 1'b0;
      rd_data        <= 64'd0;
      ddram_addr     <= 29'd0;
      ddram_burstcnt <= 8'd0;
      ddram_rd       <= 1'b0;
    end else begin
      ack      <= 3'b000;
      valid    <= 3'b000;
      wdog_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_ok) begin
            if (pick_burst == 8'd0) begin
              // Nothing to fetch: acknowledge straight away and move on.
              ack    <= 3'b001 << pick;
              rr_ptr <= next_idx(pick);
            end else begin
              gnt            <= pick;
              ddram_addr     <= pick_addr;
              ddram_burstcnt <= pick_burst;
              ddram_rd       <= 1'b1;
              state          <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!ddram_busy) begin
            ddram_rd <= 1'b0;
            ack      <= 3'b001 << gnt;
            beat_cnt <= 8'd0;
            wdog_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (wdog_cnt == WDOG_LAST) begin
            // Timeout wins over a coincident beat; that beat is dropped.
            wdog_err <= 1'b1;
            rr_ptr   <= next_idx(gnt);
            state    <= IDLE;
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
            if (ddram_valid) begin
              rd_data  <= ddram_readdata;
              valid    <= 3'b001 << gnt;
              beat_cnt <= beat_next;
              if (beat_next == ddram_burstcnt) begin
                rr_ptr <= next_idx(gnt);
                state  <= IDLE;
              end
            end
          end
        end
        default: begin
          state    <= IDLE;
          ddram_rd <= 1'b0;
        end
      endcase
    end
  end

endmodule
